// File: rtl/disp_src_scheduler_pkg.sv
// Shared definitions for the display source scheduler.
// Holds state encodings, display widths and the round-robin search.
package disp_src_scheduler_pkg;

  localparam int DEFAULT_TICK_CYCLES = 100_000;
  localparam int DISP_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SHOW = 2'd2,
    ST_PIN  = 2'd3
  } state_t;

  // Nearest requester after last wins; k=1 is assigned last.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] last,
    input int         n
  );
    logic [1:0] w;
    int idx;
    w = '0;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (req[idx[1:0]]) w = idx[1:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler with synchronous clear.
// tick is high for one cycle every TICK_CYCLES enabled cycles.
module ms_tick_gen
  import disp_src_scheduler_pkg::*;
#(
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0] cnt;

  assign tick = !clr && (cnt == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_src_scheduler.sv
// Time-shares the seven-segment display between several 16-bit sources.
// Round-robin with per-grant dwell, plus a manual pin override.
module disp_src_scheduler
  import disp_src_scheduler_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int DW          = DISP_DW,
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
  parameter int HOLD_MS     = 1000
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic [N_SRC-1:0]    src_req,
  input  logic                pin_en,
  input  logic [1:0]          pin_sel,
  output logic [DW-1:0]       disp_val,
  output logic [1:0]          disp_src,
  output logic                disp_valid,
  output logic [N_SRC-1:0]    src_gnt,
  output logic                dwell_done
);

  localparam int MSW = $clog2(HOLD_MS + 1);
  localparam logic [N_SRC-1:0] ONE =
    {{(N_SRC-1){1'b0}}, 1'b1};

  state_t state, nxt;

  logic [1:0]       last, last_d;
  logic [1:0]       win, psel, src_d;
  logic [3:0]       req4;
  logic             any_req, tick, expire, in_show;
  logic [MSW-1:0]   ms_cnt;
  logic [DW-1:0]    word [4];
  logic [DW-1:0]    val_d;
  logic [N_SRC-1:0] gnt_d;
  logic             done_d;

  for (genvar i = 0; i < 4; i++) begin : g_word
    if (i < N_SRC) begin : g_on
      assign word[i] = src_data[i*DW +: DW];
    end else begin : g_off
      assign word[i] = '0;
    end
  end

  always_comb begin
    req4 = '0;
    req4[N_SRC-1:0] = src_req;
  end

  assign any_req = |src_req;
  assign psel    = (int'(pin_sel) < N_SRC) ? pin_sel : 2'd0;
  assign win     = rr_pick(req4, last, N_SRC);
  assign in_show = (state == ST_SHOW);
  assign expire  = in_show && tick
                && (ms_cnt == MSW'(HOLD_MS - 1));

  assign disp_valid = (state == ST_SHOW)
                   || (state == ST_PIN);

  ms_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .clr       (!in_show),
    .tick      (tick)
  );

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (!in_show) begin
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (any_req) nxt = ST_ARB;
      ST_ARB:  nxt = any_req ? ST_SHOW : ST_IDLE;
      ST_SHOW: begin
        if (!req4[disp_src] || expire) nxt = ST_ARB;
      end
      ST_PIN:  nxt = ST_ARB;
      default: nxt = ST_IDLE;
    endcase
    if (pin_en) nxt = ST_PIN;
  end

  // A drop on the same cycle as expiry is a drop: no dwell_done.
  always_comb begin
    val_d  = disp_val;
    src_d  = disp_src;
    gnt_d  = src_gnt;
    done_d = 1'b0;
    last_d = last;
    if (nxt == ST_PIN) begin
      src_d = psel;
      gnt_d = ONE << psel;
      val_d = word[psel];
    end else if (nxt == ST_SHOW) begin
      if (state == ST_ARB) begin
        src_d  = win;
        gnt_d  = ONE << win;
        val_d  = word[win];
        last_d = win;
      end else begin
        val_d = word[disp_src];
      end
    end else begin
      gnt_d  = '0;
      done_d = expire && req4[disp_src];
      if (state == ST_PIN) last_d = psel;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      disp_src   <= '0;
      src_gnt    <= '0;
      dwell_done <= 1'b0;
      last       <= 2'(N_SRC - 1);
    end else begin
      disp_val   <= val_d;
      disp_src   <= src_d;
      src_gnt    <= gnt_d;
      dwell_done <= done_d;
      last       <= last_d;
    end
  end

endmodule

// File: tb/tb_disp_src_scheduler.sv
// Bench for disp_src_scheduler: directed scenarios plus random traffic,
// all checked every cycle against a cycle-count based reference model.
module tb_disp_src_scheduler;

  localparam int NS   = 4;
  localparam int DW   = 16;
  localparam int TICK = 4;
  localparam int HOLD = 3;
  localparam int DWELL = TICK * HOLD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_req = '0;
  logic              pin_en = 1'b0;
  logic [1:0]        pin_sel = '0;
  logic [DW-1:0]     disp_val;
  logic [1:0]        disp_src;
  logic              disp_valid;
  logic [NS-1:0]     src_gnt;
  logic              dwell_done;

  int n_checks = 0;
  int n_fail   = 0;

  disp_src_scheduler #(
    .N_SRC(NS), .DW(DW),
    .TICK_CYCLES(TICK), .HOLD_MS(HOLD)
  ) dut (
    .clk_100MHz(clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_req   (src_req),
    .pin_en    (pin_en),
    .pin_sel   (pin_sel),
    .disp_val  (disp_val),
    .disp_src  (disp_src),
    .disp_valid(disp_valid),
    .src_gnt   (src_gnt),
    .dwell_done(dwell_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return src_data[i*DW +: DW];
  endfunction

  // Reference model: phase 0 idle, 1 arb, 2 show, 3 pin.
  int            ph = 0;
  int            cnt = 0;
  int            last = NS - 1;
  logic [DW-1:0] e_val = '0;
  int            e_src = 0;
  logic [NS-1:0] e_gnt = '0;
  logic          e_done = 1'b0;

  always @(posedge clk) begin
    int ps, w;
    if (!rst_n) begin
      ph = 0; cnt = 0; last = NS - 1;
      e_val = '0; e_src = 0; e_gnt = '0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      ps = (int'(pin_sel) < NS) ? int'(pin_sel) : 0;
      if (pin_en) begin
        ph = 3;
        e_src = ps;
        e_gnt = NS'(1) << ps;
        e_val = word(ps);
      end else begin
        case (ph)
          0: if (src_req != 0) ph = 1;
          1: begin
            if (src_req != 0) begin
              w = 0;
              for (int k = 1; k <= NS; k++) begin
                if (src_req[(last + k) % NS]) begin
                  w = (last + k) % NS;
                  break;
                end
              end
              ph = 2; cnt = 0; last = w;
              e_src = w;
              e_gnt = NS'(1) << w;
              e_val = word(w);
            end else begin
              ph = 0;
            end
          end
          2: begin
            cnt++;
            if (!src_req[e_src]) begin
              ph = 1; e_gnt = '0;
            end else if (cnt == DWELL) begin
              ph = 1; e_gnt = '0; e_done = 1'b1;
            end else begin
              e_val = word(e_src);
            end
          end
          default: begin
            ph = 1; last = ps; e_gnt = '0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_val", 32'(disp_val), 32'h0);
      chk("rst_gnt", 32'(src_gnt), 32'h0);
      chk("rst_valid", 32'(disp_valid), 32'h0);
      chk("rst_done", 32'(dwell_done), 32'h0);
    end else begin
      chk("m_val", 32'(disp_val), 32'(e_val));
      chk("m_src", 32'(disp_src), 32'(e_src));
      chk("m_gnt", 32'(src_gnt), 32'(e_gnt));
      chk("m_valid", 32'(disp_valid),
          32'((ph == 2) || (ph == 3)));
      chk("m_done", 32'(dwell_done), 32'(e_done));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    src_data = {16'h9ABC, 16'h00FF, 16'h5678, 16'h1234};
    src_req  = 4'b1111;
    // 1 reset held with all requests
    step(3);
    chk("r_gnt", 32'(src_gnt), 32'h0);
    chk("r_val", 32'(disp_val), 32'h0);
    chk("r_src", 32'(disp_src), 32'h0);
    rst_n = 1'b1;
    step();
    chk("t1_gnt", 32'(src_gnt), 32'h0);
    step();
    chk("t2_gnt", 32'(src_gnt), 32'h1);
    chk("t2_val", 32'(disp_val), 32'h1234);
    chk("t2_valid", 32'(disp_valid), 32'h1);
    // 2 rotation
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < DWELL; k++) begin
        chk("rot_gnt", 32'(src_gnt), 32'(1 << (g % 4)));
        chk("rot_nodone", 32'(dwell_done), 32'h0);
        step();
      end
      chk("rot_arb_gnt", 32'(src_gnt), 32'h0);
      chk("rot_done", 32'(dwell_done), 32'h1);
      if (g < 4) step();
    end
    // 3 drop mid-dwell
    src_req = 4'b0110;
    step();
    chk("drop_gnt1", 32'(src_gnt), 32'h2);
    chk("drop_val1", 32'(disp_val), 32'h5678);
    step(4);
    src_req = 4'b0100;
    step();
    chk("drop_arb", 32'(src_gnt), 32'h0);
    chk("drop_nodone", 32'(dwell_done), 32'h0);
    step();
    chk("drop_gnt2", 32'(src_gnt), 32'h4);
    chk("drop_val2", 32'(disp_val), 32'h00FF);
    // 4 live tracking
    step(2);
    chk("live_old", 32'(disp_val), 32'h00FF);
    src_data[2*DW +: DW] = 16'hBEEF;
    step();
    chk("live_new", 32'(disp_val), 32'hBEEF);
    // 5 pin during src0 show
    src_req = 4'b1111;
    i = 0;
    while (i < 100 && src_gnt != 4'b0001) begin
      step();
      i++;
    end
    chk("wait_src0", 32'(src_gnt), 32'h1);
    pin_en = 1'b1;
    pin_sel = 2'd3;
    step();
    chk("pin_gnt", 32'(src_gnt), 32'h8);
    chk("pin_val", 32'(disp_val), 32'h9ABC);
    for (int k = 0; k < 49; k++) begin
      step();
      chk("pin_hold", 32'(src_gnt), 32'h8);
    end
    pin_en = 1'b0;
    step();
    chk("unpin_arb", 32'(src_gnt), 32'h0);
    step();
    chk("unpin_src0", 32'(src_gnt), 32'h1);
    // 6 idle and async reset
    src_req = 4'b0000;
    step();
    chk("idle_arb", 32'(src_gnt), 32'h0);
    step();
    chk("idle_valid", 32'(disp_valid), 32'h0);
    chk("idle_val", 32'(disp_val), 32'h1234);
    src_req = 4'b0001;
    step(2);
    chk("re_gnt", 32'(src_gnt), 32'h1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(src_gnt), 32'h0);
    chk("arst_val", 32'(disp_val), 32'h0);
    chk("arst_valid", 32'(disp_valid), 32'h0);
    step(2);
    rst_n = 1'b1;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0)
        src_req = NS'($urandom);
      if ($urandom_range(63) == 0)
        pin_en = ~pin_en;
      if ($urandom_range(7) == 0)
        pin_sel = 2'($urandom);
      if ($urandom_range(3) == 0)
        src_data[$urandom_range(NS-1)*DW +: DW] = DW'($urandom);
      if (c % 1000 == 999) begin
        #2;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step();
    end
    pin_en = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
